// File: rtl/fetch_stage_bp_if.sv
// Fetch-stage bundle: IMEM side, Decode side, EX resolution/redirect inputs and statistics.
interface fetch_stage_bp_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic [31:0]     idata;
  logic [XLEN-1:0] iaddr;
  logic [31:0]     idata_out;
  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic [XLEN-1:0] address_predicted;
  logic            res_valid;
  logic [XLEN-1:0] res_pc;
  logic            res_taken;
  logic            mispredict;
  logic [XLEN-1:0] branch_addr;
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;

  modport slave (
    input  stall, idata, res_valid, res_pc, res_taken, mispredict, branch_addr,
    output iaddr, idata_out, pc, pred_taken, address_predicted, stat_branches, stat_mispredicts
  );

  modport master (
    output stall, idata, res_valid, res_pc, res_taken, mispredict, branch_addr,
    input  iaddr, idata_out, pc, pred_taken, address_predicted, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/fetch_stage_bp.sv
// Instruction fetch stage: PC register, JAL/branch pre-decode, next-PC prediction
// (always-taken, BTFN or bimodal 2-bit BHT), EX redirect and saturating statistics.
module fetch_stage_bp #(
  parameter int              XLEN        = 32,
  parameter int              BHT_ENTRIES = 64,
  parameter logic [XLEN-1:0] RESET_PC    = {XLEN{1'b0}},
  parameter int              PRED_MODE   = 2
) (
  input  logic             clk,
  input  logic             reset,
  fetch_stage_bp_if.slave  bus
);
  localparam int         IDXW      = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [XLEN-1:0] FOUR = {{(XLEN-3){1'b0}}, 3'b100};

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] next_pc_s;
  logic [XLEN-1:0] imm_j_s;
  logic [XLEN-1:0] imm_b_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] addr_pred_s;
  logic            is_jal_s;
  logic            is_branch_s;
  logic            br_taken_s;
  logic            bht_taken_s;
  logic            pred_taken_s;
  logic [31:0]     stat_br_r;
  logic [31:0]     stat_mp_r;
  logic            unused_s;

  assign imm_j_s = {{(XLEN-21){bus.idata[31]}}, bus.idata[31], bus.idata[19:12],
                    bus.idata[20], bus.idata[30:21], 1'b0};
  assign imm_b_s = {{(XLEN-13){bus.idata[31]}}, bus.idata[31], bus.idata[7],
                    bus.idata[30:25], bus.idata[11:8], 1'b0};

  // Pre-decode: anything that is not JAL or BRANCH (including unknown words) falls through as pc+4
  always_comb begin
    imm_s       = FOUR;
    is_jal_s    = 1'b0;
    is_branch_s = 1'b0;
    case (bus.idata[6:0])
      OP_JAL: begin
        imm_s    = imm_j_s;
        is_jal_s = 1'b1;
      end
      OP_BRANCH: begin
        imm_s       = imm_b_s;
        is_branch_s = 1'b1;
      end
      default: begin
        imm_s       = FOUR;
        is_jal_s    = 1'b0;
        is_branch_s = 1'b0;
      end
    endcase
  end

  // Conditional-branch direction by predictor mode
  always_comb begin
    br_taken_s = 1'b0;
    case (PRED_MODE)
      0:       br_taken_s = 1'b1;
      1:       br_taken_s = imm_s[XLEN-1];
      default: br_taken_s = bht_taken_s;
    endcase
  end

  assign pred_taken_s = is_jal_s | (is_branch_s & br_taken_s);
  assign addr_pred_s  = pc_r + (pred_taken_s ? imm_s : FOUR);

  // Next PC: EX redirect beats a decode stall
  always_comb begin
    next_pc_s = addr_pred_s;
    if (bus.mispredict) begin
      next_pc_s = bus.branch_addr;
    end else if (bus.stall) begin
      next_pc_s = pc_r;
    end else begin
      next_pc_s = addr_pred_s;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // Saturating statistics, counted regardless of stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_br_r <= 32'd0;
      stat_mp_r <= 32'd0;
    end else begin
      if (bus.res_valid && (stat_br_r != 32'hFFFF_FFFF)) begin
        stat_br_r <= stat_br_r + 32'd1;
      end
      if (bus.mispredict && (stat_mp_r != 32'hFFFF_FFFF)) begin
        stat_mp_r <= stat_mp_r + 32'd1;
      end
    end
  end

  generate
    if (PRED_MODE == 2) begin : g_bht
      logic [1:0]      bht_r [BHT_ENTRIES];
      logic [IDXW-1:0] rd_idx_s;
      logic [IDXW-1:0] wr_idx_s;

      assign rd_idx_s    = pc_r[IDXW+1:2];
      assign wr_idx_s    = bus.res_pc[IDXW+1:2];
      assign bht_taken_s = bht_r[rd_idx_s][1];

      // 2-bit saturating counters; lookup this cycle sees the value before the edge
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_r[i] <= 2'b01;
          end
        end else if (bus.res_valid) begin
          if (bus.res_taken && (bht_r[wr_idx_s] != 2'b11)) begin
            bht_r[wr_idx_s] <= bht_r[wr_idx_s] + 2'b01;
          end else if (!bus.res_taken && (bht_r[wr_idx_s] != 2'b00)) begin
            bht_r[wr_idx_s] <= bht_r[wr_idx_s] - 2'b01;
          end
        end
      end
    end else begin : g_no_bht
      assign bht_taken_s = 1'b0;
    end
  endgenerate

  assign unused_s = ^{bus.res_pc, bus.res_taken};

  assign bus.iaddr             = pc_r;
  assign bus.pc                = pc_r;
  assign bus.idata_out         = bus.idata;
  assign bus.pred_taken        = pred_taken_s;
  assign bus.address_predicted = addr_pred_s;
  assign bus.stat_branches     = stat_br_r;
  assign bus.stat_mispredicts  = stat_mp_r;
endmodule

// File: tb/tb_fetch_stage_bp.sv
// Scoreboard bench for fetch_stage_bp: a bimodal (mode 2) and a BTFN (mode 1) instance share stimulus.
module tb_fetch_stage_bp;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] BEQM8  = 32'hFE00_0CE3;  // beq x0,x0,-8
  localparam logic [31:0] BEQP8  = 32'h0000_0463;  // beq x0,x0,+8
  localparam logic [31:0] JAL16  = 32'h0100_006F;  // jal x0,+16

  localparam int K_PC = 0, K_IADDR = 1, K_PRED = 2, K_ADDR = 3, K_STATB = 4,
                 K_STATM = 5, K_PRED1 = 6, K_ADDR1 = 7, K_IDOUT = 8, K_PC1 = 9;

  typedef struct {
    int          kind;
    logic [31:0] val;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  fetch_stage_bp_if #(.XLEN(XLEN)) bus ();
  fetch_stage_bp_if #(.XLEN(XLEN)) bus1 ();

  assign bus1.stall       = bus.stall;
  assign bus1.idata       = bus.idata;
  assign bus1.res_valid   = bus.res_valid;
  assign bus1.res_pc      = bus.res_pc;
  assign bus1.res_taken   = bus.res_taken;
  assign bus1.mispredict  = bus.mispredict;
  assign bus1.branch_addr = bus.branch_addr;

  fetch_stage_bp #(.XLEN(XLEN), .BHT_ENTRIES(64), .RESET_PC(32'h0), .PRED_MODE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  fetch_stage_bp #(.XLEN(XLEN), .BHT_ENTRIES(64), .RESET_PC(32'h0), .PRED_MODE(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_PC:    return bus.pc;
      K_IADDR: return bus.iaddr;
      K_PRED:  return {31'd0, bus.pred_taken};
      K_ADDR:  return bus.address_predicted;
      K_STATB: return bus.stat_branches;
      K_STATM: return bus.stat_mispredicts;
      K_PRED1: return {31'd0, bus1.pred_taken};
      K_ADDR1: return bus1.address_predicted;
      K_IDOUT: return bus.idata_out;
      K_PC1:   return bus1.pc;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input int k, input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = cyc_cnt;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, sampled on the falling edge
  initial begin
    exp_t e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
        e = q.pop_front();
        a = actual(e.kind);
        n_cmp++;
        if (e.cyc != cyc_cnt || a !== e.val) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, a, e.val, e.cyc);
        end
      end
    end
  end

  initial begin
    reset           = 1'b0;
    bus.stall       = 1'b0;
    bus.idata       = NOP;
    bus.res_valid   = 1'b0;
    bus.res_pc      = 32'h0;
    bus.res_taken   = 1'b0;
    bus.mispredict  = 1'b0;
    bus.branch_addr = 32'h0;
    step();
    // reset state and fresh lookups; mode 1 backward branch at pc 0 wraps below zero
    step();
    bus.stall = 1'b1;
    bus.idata = BEQM8;
    reset     = 1'b1;
    expect_val(K_PC, 32'h0, "reset_pc");
    expect_val(K_STATB, 32'h0, "reset_statb");
    expect_val(K_STATM, 32'h0, "reset_statm");
    expect_val(K_PRED, 32'h0, "reset_bht_nt");
    expect_val(K_ADDR, 32'h4, "reset_bht_addr");
    expect_val(K_PRED1, 32'h1, "m1_back_taken_pc0");
    expect_val(K_ADDR1, 32'hFFFF_FFF8, "m1_wrap_addr");
    step();
    bus.stall = 1'b0;
    bus.idata = NOP;
    expect_val(K_PC, 32'h0, "stall_after_reset");
    expect_val(K_PRED, 32'h0, "nop_not_taken");
    expect_val(K_ADDR, 32'h4, "nop_addr");
    expect_val(K_IDOUT, NOP, "idata_out_nop");
    step(); expect_val(K_PC, 32'h4, "seq_pc4");
    step(); expect_val(K_PC, 32'h8, "seq_pc8"); bus.stall = 1'b1;
    step(); expect_val(K_PC, 32'h8, "stall1");
    step(); expect_val(K_PC, 32'h8, "stall2");
    step(); expect_val(K_PC, 32'h8, "stall3"); bus.stall = 1'b0;
    step(); expect_val(K_PC, 32'hC, "after_stall");
    bus.res_valid = 1'b1; bus.res_pc = 32'h8; bus.res_taken = 1'b1;
    step();
    step(); bus.res_valid = 1'b0;
    repeat (11) step();
    expect_val(K_PC, 32'h40, "seq_pc40");
    expect_val(K_STATB, 32'd2, "statb_pre_reset");
    bus.stall = 1'b1;
    // mid-run reset with pending EX inputs that must be ignored
    step();
    reset = 1'b0;
    bus.mispredict = 1'b1; bus.branch_addr = 32'h300;
    bus.res_valid = 1'b1; bus.res_pc = 32'h8; bus.res_taken = 1'b1;
    #1;
    expect_val(K_PC, 32'h0, "midreset_pc");
    expect_val(K_IADDR, 32'h0, "midreset_iaddr");
    expect_val(K_STATB, 32'h0, "midreset_statb");
    expect_val(K_STATM, 32'h0, "midreset_statm");
    step();
    reset = 1'b1; bus.mispredict = 1'b0; bus.res_valid = 1'b0; bus.stall = 1'b0;
    expect_val(K_PC, 32'h0, "reset_ignores_redirect");
    expect_val(K_STATM, 32'h0, "reset_ignores_mp");
    expect_val(K_STATB, 32'h0, "reset_ignores_res");
    step(); expect_val(K_PC, 32'h4, "post_reset_pc4");
    // bimodal training at pc 0x8 (index 2) under stall
    step();
    expect_val(K_PC, 32'h8, "post_reset_pc8");
    bus.stall = 1'b1; bus.idata = BEQM8;
    bus.res_valid = 1'b1; bus.res_pc = 32'h8; bus.res_taken = 1'b1;
    expect_val(K_PRED, 32'h0, "bht_fresh_same_cycle");
    expect_val(K_ADDR, 32'hC, "bht_fresh_addr");
    expect_val(K_PRED1, 32'h1, "m1_backward_taken");
    expect_val(K_ADDR1, 32'h0, "m1_backward_addr");
    step(); expect_val(K_PRED, 32'h1, "bht_10_taken"); expect_val(K_ADDR, 32'h0, "bht_10_addr");
    step(); expect_val(K_PRED, 32'h1, "bht_11");
    step(); bus.res_taken = 1'b0; expect_val(K_PRED, 32'h1, "bht_sat_high");
    step(); expect_val(K_PRED, 32'h1, "bht_nt1_10");
    step(); expect_val(K_PRED, 32'h0, "bht_nt2_01"); expect_val(K_ADDR, 32'hC, "bht_01_addr");
    step(); expect_val(K_PRED, 32'h0, "bht_nt3_00");
    step(); bus.res_taken = 1'b1; expect_val(K_PRED, 32'h0, "bht_sat_low");
    step();
    bus.res_valid = 1'b0; bus.idata = BEQP8;
    expect_val(K_PRED, 32'h0, "bht_back_01");
    expect_val(K_STATB, 32'd8, "statb_count");
    expect_val(K_ADDR, 32'hC, "m2_fwd_addr");
    expect_val(K_PRED1, 32'h0, "m1_forward_nt");
    expect_val(K_ADDR1, 32'hC, "m1_forward_addr");
    step(); bus.stall = 1'b0; bus.idata = NOP; expect_val(K_PC, 32'h8, "held_during_train");
    step(); expect_val(K_PC, 32'hC, "seq_pcC");
    step();
    // JAL at 0x10
    bus.idata = JAL16;
    expect_val(K_PC, 32'h10, "jal_pc");
    expect_val(K_PRED, 32'h1, "jal_taken");
    expect_val(K_ADDR, 32'h20, "jal_addr");
    expect_val(K_IDOUT, JAL16, "idata_out_jal");
    step();
    bus.idata = NOP;
    expect_val(K_PC, 32'h20, "jal_next_pc");
    expect_val(K_IADDR, 32'h20, "jal_next_iaddr");
    bus.stall = 1'b1; bus.mispredict = 1'b1; bus.branch_addr = 32'h200;
    step();
    bus.mispredict = 1'b0; bus.stall = 1'b0;
    expect_val(K_PC, 32'h200, "redirect_over_stall");
    expect_val(K_IADDR, 32'h200, "redirect_iaddr");
    expect_val(K_PC1, 32'h200, "m1_redirect");
    expect_val(K_STATM, 32'd1, "statm_one");
    expect_val(K_STATB, 32'd8, "statb_hold");
    step(); expect_val(K_PC, 32'h204, "post_redirect_seq");
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      step();
    end
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
      n_bad = n_bad + q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
